ram2e_cmd_seq: RTL and testbench

- Upstream command sequencer for the RAM2E control path.
- Watches writes to the RAMWorks bank register and matches the magic unlock byte sequence.
- Produces the 3-bit command-sequence state CS and the level-type data-phase command flags CmdRWMaskSet / CmdLEDSet.
- The UFM/config stage consumes these: it decodes the command byte while CS==6, and applies data bytes while a Cmd flag is high.

---
 rtl/ram2e_cmd_seq.sv | 109 ++++++++++
 tb/tb_ram2e_cmd_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram2e_cmd_seq.sv
// RAM2E upstream command sequencer: tracks the magic unlock byte sequence written
// to the RAMWorks bank register and raises the data-phase command flags.
module ram2e_cmd_seq #(
    parameter int unsigned         TO_BITS  = 20,
    parameter logic [TO_BITS-1:0]  TO_LIMIT = '1
) (
    input  logic       C14M,
    input  logic       nRES,
    input  logic [3:0] S,
    input  logic       RWSel,
    input  logic [7:0] D,
    output logic [2:0] CS,
    output logic       CmdRWMaskSet,
    output logic       CmdLEDSet,
    output logic       SeqActive
);

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_GOT_FF = 3'd1,
        CS_GOT_00 = 3'd2,
        CS_GOT_55 = 3'd3,
        CS_GOT_AA = 3'd4,
        CS_GOT_C1 = 3'd5,
        CS_CMD    = 3'd6,
        CS_DATA   = 3'd7
    } cs_t;

    cs_t                state, state_nxt;
    logic               mask_nxt, led_nxt;
    logic [TO_BITS-1:0] to_cnt;
    logic               ev;
    logic               timeout;

    assign ev        = (S == 4'hC) && RWSel;
    assign timeout   = (to_cnt == TO_LIMIT) && !ev && (state != CS_IDLE);
    assign CS        = state;
    assign SeqActive = (state != CS_IDLE);

    always_ff @(posedge C14M or negedge nRES) begin
        if (!nRES) begin
            state        <= CS_IDLE;
            CmdRWMaskSet <= 1'b0;
            CmdLEDSet    <= 1'b0;
        end else begin
            state        <= state_nxt;
            CmdRWMaskSet <= mask_nxt;
            CmdLEDSet    <= led_nxt;
        end
    end

    // Inactivity counter saturates at TO_LIMIT; any bank write or idle state clears it.
    always_ff @(posedge C14M or negedge nRES) begin
        if (!nRES) begin
            to_cnt <= '0;
        end else if (ev || state == CS_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = CmdRWMaskSet;
        led_nxt   = CmdLEDSet;
        if (timeout) begin
            state_nxt = CS_IDLE;
            mask_nxt  = 1'b0;
            led_nxt   = 1'b0;
        end else if (ev) begin
            unique case (state)
                CS_IDLE:   if (D == 8'hFF) state_nxt = CS_GOT_FF;
                CS_GOT_FF: state_nxt = (D == 8'h00) ? CS_GOT_00 :
                                       (D == 8'hFF) ? CS_GOT_FF : CS_IDLE;
                CS_GOT_00: state_nxt = (D == 8'h55) ? CS_GOT_55 :
                                       (D == 8'hFF) ? CS_GOT_FF : CS_IDLE;
                CS_GOT_55: state_nxt = (D == 8'hAA) ? CS_GOT_AA :
                                       (D == 8'hFF) ? CS_GOT_FF : CS_IDLE;
                CS_GOT_AA: state_nxt = (D == 8'hC1) ? CS_GOT_C1 :
                                       (D == 8'hFF) ? CS_GOT_FF : CS_IDLE;
                CS_GOT_C1: state_nxt = CS_CMD;
                CS_CMD: begin
                    // Other command bytes are decoded downstream from the CS6 byte itself.
                    if (D == 8'hE0) begin
                        state_nxt = CS_DATA;
                        mask_nxt  = 1'b1;
                        led_nxt   = 1'b0;
                    end else if (D == 8'hE2) begin
                        state_nxt = CS_DATA;
                        mask_nxt  = 1'b0;
                        led_nxt   = 1'b1;
                    end else begin
                        state_nxt = CS_IDLE;
                        mask_nxt  = 1'b0;
                        led_nxt   = 1'b0;
                    end
                end
                CS_DATA: begin
                    state_nxt = CS_IDLE;
                    mask_nxt  = 1'b0;
                    led_nxt   = 1'b0;
                end
                default: state_nxt = CS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram2e_cmd_seq.sv
// Directed bench for ram2e_cmd_seq with a shortened inactivity timeout (limit 9).
module tb_ram2e_cmd_seq;

    localparam int unsigned LIM = 9;

    logic       C14M;
    logic       nRES;
    logic [3:0] S;
    logic       RWSel;
    logic [7:0] D;
    logic [2:0] CS;
    logic       CmdRWMaskSet;
    logic       CmdLEDSet;
    logic       SeqActive;

    int checks = 0;
    int errors = 0;

    ram2e_cmd_seq #(
        .TO_BITS (4),
        .TO_LIMIT(4'd9)
    ) dut (
        .C14M        (C14M),
        .nRES        (nRES),
        .S           (S),
        .RWSel       (RWSel),
        .D           (D),
        .CS          (CS),
        .CmdRWMaskSet(CmdRWMaskSet),
        .CmdLEDSet   (CmdLEDSet),
        .SeqActive   (SeqActive)
    );

    initial C14M = 1'b0;
    always #5 C14M = ~C14M;

    task automatic chk(input string tag, input logic [2:0] cs_e, input logic m_e,
                       input logic l_e);
        logic [5:0] obs, exp;
        obs = {CS, CmdRWMaskSet, CmdLEDSet, SeqActive};
        exp = {cs_e, m_e, l_e, (cs_e != 3'd0)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed CS=%0d mask=%b led=%b act=%b, expected CS=%0d mask=%b led=%b act=%b",
                   tag, obs[5:3], obs[2], obs[1], obs[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One bus cycle with given S/RWSel/D, then bus returns to idle.
    task automatic bus(input logic [3:0] s_v, input logic rw, input logic [7:0] d_v);
        @(negedge C14M);
        S = s_v; RWSel = rw; D = d_v;
        @(posedge C14M);
        #1;
        S = 4'h0; RWSel = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d_v);
        bus(4'hC, 1'b1, d_v);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge C14M);
        #1;
    endtask

    task automatic prefix();
        wr(8'hFF); wr(8'h00); wr(8'h55); wr(8'hAA); wr(8'hC1); wr(8'h12);
    endtask

    initial begin
        nRES = 1'b0; S = 4'h0; RWSel = 1'b0; D = 8'h00;
        #3;
        chk("reset", 3'd0, 1'b0, 1'b0);
        #9 nRES = 1'b1;

        // Capacity-mask command
        wr(8'hFF); chk("m_ff", 3'd1, 0, 0);
        wr(8'h00); chk("m_00", 3'd2, 0, 0);
        wr(8'h55); chk("m_55", 3'd3, 0, 0);
        wr(8'hAA); chk("m_aa", 3'd4, 0, 0);
        wr(8'hC1); chk("m_c1", 3'd5, 0, 0);
        wr(8'h12); chk("m_pre", 3'd6, 0, 0);
        wr(8'hE0); chk("m_e0", 3'd7, 1, 0);
        bus(4'h5, 1'b1, 8'hFF); chk("hold_s5", 3'd7, 1, 0);
        bus(4'hC, 1'b0, 8'hFF); chk("hold_norw", 3'd7, 1, 0);
        wr(8'h3F); chk("m_data", 3'd0, 0, 0);

        // LED command
        prefix(); chk("l_pre", 3'd6, 0, 0);
        wr(8'hE2); chk("l_e2", 3'd7, 0, 1);
        wr(8'h01); chk("l_data", 3'd0, 0, 0);

        // Mismatch and FF restart
        wr(8'hFF); chk("r_ff", 3'd1, 0, 0);
        wr(8'h00); chk("r_00", 3'd2, 0, 0);
        wr(8'h12); chk("r_bad", 3'd0, 0, 0);
        wr(8'hFF); chk("r_ff1", 3'd1, 0, 0);
        wr(8'hFF); chk("r_ff2", 3'd1, 0, 0);
        wr(8'h00); chk("r_00b", 3'd2, 0, 0);
        wr(8'hFF); chk("r_ff3", 3'd1, 0, 0);
        wr(8'h00); wr(8'h55); wr(8'hFF); chk("r_ff_cs3", 3'd1, 0, 0);
        wr(8'h00); wr(8'h55); wr(8'hAA); wr(8'hFF); chk("r_ff_cs4", 3'd1, 0, 0);
        wr(8'h34); chk("r_abort", 3'd0, 0, 0);

        // FF as prefix byte is ordinary; unknown command returns to idle
        wr(8'hFF); wr(8'h00); wr(8'h55); wr(8'hAA); wr(8'hC1);
        wr(8'hFF); chk("fd_pre_ff", 3'd6, 0, 0);
        wr(8'hFD); chk("fd_cmd", 3'd0, 0, 0);

        // Timeout: counter reaches limit after LIM idle edges, abort on the next
        wr(8'hFF); wr(8'h00); wr(8'h55); chk("t_cs3", 3'd3, 0, 0);
        idle(LIM); chk("t_sat", 3'd3, 0, 0);
        idle(1); chk("t_abort", 3'd0, 0, 0);

        // EV landing on the saturation cycle wins and clears the counter
        wr(8'hFF); wr(8'h00); wr(8'h55);
        idle(LIM);
        wr(8'hAA); chk("t_evwin", 3'd4, 0, 0);
        idle(LIM); chk("t_cleared", 3'd4, 0, 0);
        idle(1); chk("t_abort2", 3'd0, 0, 0);

        // Timeout from CS7 clears the flag
        prefix(); wr(8'hE0); chk("t7_set", 3'd7, 1, 0);
        idle(LIM + 1); chk("t7_abort", 3'd0, 0, 0);

        // Asynchronous reset mid-cycle
        prefix(); wr(8'hE0); chk("ar_set", 3'd7, 1, 0);
        #2 nRES = 1'b0;
        #1 chk("ar_async", 3'd0, 0, 0);
        @(negedge C14M);
        nRES = 1'b1;
        bus(4'h5, 1'b1, 8'hFF); chk("ar_s5", 3'd0, 0, 0);
        wr(8'h00); chk("ar_noprog", 3'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
